// File: rtl/mc_mem_arbiter.sv
// Two-requester arbiter for the unified instruction/data memory of the
// multicycle RISC-V core. Requester 0 is the core memory port and requester 1
// is the program loader/debug port. Only one transaction is in flight at a
// time. The memory has a fixed latency, and each access uses a req/gnt/rvalid
// handshake. The core has fixed priority, and a starvation guard forces a
// loader grant after STARVE_MAX consecutive core wins.
module mc_mem_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   // core memory port
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_adr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   // loader / debug port
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_adr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   // memory side
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Both the latency and starvation parameters are limited to 1..15.
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10
   } state_t;

   state_t           state;
   logic             owner;       // 0 = core, 1 = loader
   logic             owner_we;    // latched write flag of the in-flight access
   logic [CNT_W-1:0] lat_cnt;     // cycles left until mem_rdata is valid, this one included
   logic [CNT_W-1:0] starve_cnt;  // consecutive core grants taken while the loader waited

   // Arbitration. A grant is possible only in IDLE, and never while reset is asserted.
   always_comb begin
      core_gnt = 1'b0;
      ld_gnt   = 1'b0;
      if (rst && (state == S_IDLE)) begin
         if (core_req && ld_req) begin
            if (starve_cnt == STARVE_LIM) begin
               ld_gnt = 1'b1;
            end else begin
               core_gnt = 1'b1;
            end
         end else begin
            core_gnt = core_req;
            ld_gnt   = ld_req;
         end
      end
   end

   // Read data is passed through only to the owner and only on a read completion.
   assign core_rdata = (core_rvalid && !owner_we) ? mem_rdata : '0;
   assign ld_rdata   = (ld_rvalid   && !owner_we) ? mem_rdata : '0;

   // Sequencer: IDLE -> ISSUE -> WAIT -> IDLE. Memory strobes and completion pulses are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         owner       <= 1'b0;
         owner_we    <= 1'b0;
         lat_cnt     <= '0;
         starve_cnt  <= '0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_adr     <= '0;
         mem_wdata   <= '0;
         core_rvalid <= 1'b0;
         ld_rvalid   <= 1'b0;
      end else begin
         mem_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (core_gnt || ld_gnt) begin
                  owner     <= ld_gnt;
                  owner_we  <= ld_gnt ? ld_we : core_we;
                  mem_we    <= ld_gnt ? ld_we : core_we;
                  mem_adr   <= ld_gnt ? ld_adr : core_adr;
                  mem_wdata <= ld_gnt ? ld_wdata : core_wdata;
                  mem_en    <= 1'b1;
                  state     <= S_ISSUE;
               end
               // The loader's wait streak ends when it is served or stops asking.
               if (ld_gnt || !ld_req) begin
                  starve_cnt <= '0;
               end else if (core_gnt && (starve_cnt != STARVE_LIM)) begin
                  starve_cnt <= starve_cnt + CNT_W'(1);
               end
            end
            S_ISSUE: begin
               lat_cnt <= LAT_LOAD;
               // With a single-cycle memory, the completion cycle is the first WAIT cycle.
               if (LAT_LOAD == CNT_W'(1)) begin
                  core_rvalid <= !owner;
                  ld_rvalid   <= owner;
               end
               state <= S_WAIT;
            end
            S_WAIT: begin
               lat_cnt <= lat_cnt - CNT_W'(1);
               if (lat_cnt == CNT_W'(1)) begin
                  // mem_rdata is valid in this cycle, and the counter reaches 0.
                  core_rvalid <= 1'b0;
                  ld_rvalid   <= 1'b0;
                  state       <= S_IDLE;
               end else if (lat_cnt == CNT_W'(2)) begin
                  core_rvalid <= !owner;
                  ld_rvalid   <= owner;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_mem_arbiter.sv
// Directed testbench for mc_mem_arbiter with MEM_LAT=2 and STARVE_MAX=4.
module tb_mc_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst;
   logic          core_req;
   logic          core_we;
   logic [AW-1:0] core_adr;
   logic [DW-1:0] core_wdata;
   logic          core_gnt;
   logic          core_rvalid;
   logic [DW-1:0] core_rdata;
   logic          ld_req;
   logic          ld_we;
   logic [AW-1:0] ld_adr;
   logic [DW-1:0] ld_wdata;
   logic          ld_gnt;
   logic          ld_rvalid;
   logic [DW-1:0] ld_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int total;
   int bad;
   int cyc;
   int hits_300;

   mc_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(4)
   ) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: 256 words, two-cycle read latency, and filler data when no read is returning.
   logic [DW-1:0] mem [256];
   logic          p1_v, p2_v;
   logic [AW-1:0] p1_a, p2_a;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
      mem[16] = 32'hDEADBEEF;
   end

   always @(posedge clk) begin
      p1_v <= mem_en;
      p1_a <= mem_adr;
      p2_v <= p1_v;
      p2_a <= p1_a;
      if (mem_en && mem_we) mem[mem_adr[9:2]] <= mem_wdata;
   end

   assign mem_rdata = p2_v ? mem[p2_a[9:2]] : 32'hA5A5A5A5;

   // Count every strobe aimed at the address of the core request that was withdrawn.
   always @(negedge clk) if (mem_en && mem_adr == 32'h300) hits_300++;

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      return (a == 32'h40) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
   endfunction

   task automatic drive_pt();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [199:0] outs;
      rst = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_adr = 32'h80; core_wdata = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_adr = '0; ld_wdata = '0;
      @(negedge clk);
      outs = {core_gnt, ld_gnt, core_rvalid, ld_rvalid, mem_en, mem_we, mem_adr, mem_wdata, core_rdata, ld_rdata};
      total++;
      if (outs !== '0) begin bad++; $display("FAIL reset_outs: got %h want 0", outs); end
      drive_pt();
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (core_gnt !== 1'b1) begin bad++; $display("FAIL reset_first_gnt: got %b want 1", core_gnt); end
      drive_pt();
      core_req = 1'b0;
      drive_pt();
      // The FSM is in WAIT now, so reset is applied in mid-transaction.
      #2 rst = 1'b0;
      #1;
      outs = {core_gnt, ld_gnt, core_rvalid, ld_rvalid, mem_en, mem_we, mem_adr, mem_wdata, core_rdata, ld_rdata};
      total++;
      if (outs !== '0) begin bad++; $display("FAIL reset_midwait_outs: got %h want 0", outs); end
      drive_pt();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if ({core_rvalid, ld_rvalid} !== 2'b00) begin
            bad++; $display("FAIL reset_no_rvalid: cycle %0d got %b want 00", i, {core_rvalid, ld_rvalid});
         end
      end
      drive_pt();
      core_req = 1'b1; core_adr = 32'h40;
      @(negedge clk);
      total++;
      if (core_gnt !== 1'b1) begin bad++; $display("FAIL reset_regrant: got %b want 1", core_gnt); end
      drive_pt();
      core_req = 1'b0;
      repeat (4) drive_pt();
   endtask

   task automatic test_core_read();
      core_req = 1'b1; core_we = 1'b0; core_adr = 32'h40;
      @(negedge clk);
      total++;
      if ({core_gnt, ld_gnt} !== 2'b10) begin bad++; $display("FAIL rd_gnt: got %b want 10", {core_gnt, ld_gnt}); end
      drive_pt();
      core_req = 1'b0; core_adr = 32'hFFFC;
      @(negedge clk);
      total++;
      if ({mem_en, mem_we, mem_adr} !== {1'b1, 1'b0, 32'h40}) begin
         bad++; $display("FAIL rd_issue: got en=%b we=%b adr=%h want 1 0 00000040", mem_en, mem_we, mem_adr);
      end
      drive_pt();
      @(negedge clk);
      total++;
      if ({mem_en, core_rvalid} !== 2'b00) begin bad++; $display("FAIL rd_wait: got %b want 00", {mem_en, core_rvalid}); end
      drive_pt();
      @(negedge clk);
      total++;
      if ({core_rvalid, core_rdata, ld_rvalid, ld_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
         bad++; $display("FAIL rd_complete: got rv=%b rd=%h ldrv=%b ldrd=%h want 1 deadbeef 0 0",
                         core_rvalid, core_rdata, ld_rvalid, ld_rdata);
      end
      drive_pt();
      @(negedge clk);
      total++;
      if (core_rvalid !== 1'b0) begin bad++; $display("FAIL rd_pulse_width: got %b want 0", core_rvalid); end
   endtask

   task automatic test_loader_write();
      drive_pt();
      ld_req = 1'b1; ld_we = 1'b1; ld_adr = 32'h100; ld_wdata = 32'h12345678;
      @(negedge clk);
      total++;
      if ({core_gnt, ld_gnt} !== 2'b01) begin bad++; $display("FAIL wr_gnt: got %b want 01", {core_gnt, ld_gnt}); end
      drive_pt();
      ld_req = 1'b0; ld_wdata = 32'h0; ld_we = 1'b0;
      @(negedge clk);
      total++;
      if ({mem_en, mem_we, mem_adr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'h12345678}) begin
         bad++; $display("FAIL wr_issue: got en=%b we=%b adr=%h wd=%h want 1 1 00000100 12345678",
                         mem_en, mem_we, mem_adr, mem_wdata);
      end
      drive_pt();
      drive_pt();
      @(negedge clk);
      total++;
      if ({ld_rvalid, ld_rdata, core_rvalid, core_rdata} !== {1'b1, 32'h0, 1'b0, 32'h0}) begin
         bad++; $display("FAIL wr_complete: got ldrv=%b ldrd=%h rv=%b rd=%h want 1 0 0 0",
                         ld_rvalid, ld_rdata, core_rvalid, core_rdata);
      end
      drive_pt();
   endtask

   task automatic test_starvation();
      logic exp_w [10];
      logic got_w [10];
      int   gcyc  [10];
      int   ng;
      int   dbl;
      ng = 0; dbl = 0;
      for (int i = 0; i < 10; i++) begin exp_w[i] = (i == 4 || i == 9); got_w[i] = 1'b0; gcyc[i] = 0; end
      core_req = 1'b1; core_we = 1'b0; core_adr = 32'h200;
      ld_req = 1'b1; ld_we = 1'b0; ld_adr = 32'h340;
      for (int n = 0; n < 80 && ng < 10; n++) begin
         @(negedge clk);
         if (core_gnt && ld_gnt) dbl++;
         if (core_gnt || ld_gnt) begin
            got_w[ng] = ld_gnt; gcyc[ng] = cyc; ng++;
         end
         drive_pt();
      end
      core_req = 1'b0; ld_req = 1'b0;
      total++;
      if (ng !== 10) begin bad++; $display("FAIL starve_count: got %0d grants want 10", ng); end
      for (int i = 0; i < 10; i++) begin
         total++;
         if (got_w[i] !== exp_w[i]) begin
            bad++; $display("FAIL starve_order[%0d]: got winner %0d want %0d", i, got_w[i], exp_w[i]);
         end
      end
      total++;
      if (dbl !== 0) begin bad++; $display("FAIL starve_double_gnt: got %0d want 0", dbl); end
      total++;
      if (gcyc[4] - gcyc[3] !== 4) begin bad++; $display("FAIL starve_spacing: got %0d want 4", gcyc[4] - gcyc[3]); end
      repeat (6) drive_pt();
   endtask

   task automatic test_core_drop();
      hits_300 = 0;
      core_req = 1'b1; core_we = 1'b0; core_adr = 32'h20;
      @(negedge clk);
      total++;
      if (core_gnt !== 1'b1) begin bad++; $display("FAIL drop_first_gnt: got %b want 1", core_gnt); end
      drive_pt();
      core_req = 1'b0;
      drive_pt();
      drive_pt();
      core_req = 1'b1; core_adr = 32'h300;
      ld_req = 1'b1; ld_we = 1'b0; ld_adr = 32'h180;
      @(negedge clk);
      total++;
      if ({core_gnt, ld_gnt, core_rvalid, core_rdata} !== {2'b00, 1'b1, 32'hC0DE0020}) begin
         bad++; $display("FAIL drop_busy: got g=%b%b rv=%b rd=%h want 00 1 c0de0020",
                         core_gnt, ld_gnt, core_rvalid, core_rdata);
      end
      drive_pt();
      core_req = 1'b0;
      @(negedge clk);
      total++;
      if ({core_gnt, ld_gnt} !== 2'b01) begin bad++; $display("FAIL drop_ld_gnt: got %b want 01", {core_gnt, ld_gnt}); end
      drive_pt();
      ld_req = 1'b0;
      @(negedge clk);
      total++;
      if ({mem_en, mem_adr} !== {1'b1, 32'h180}) begin
         bad++; $display("FAIL drop_issue: got en=%b adr=%h want 1 00000180", mem_en, mem_adr);
      end
      drive_pt();
      drive_pt();
      @(negedge clk);
      total++;
      if ({ld_rvalid, ld_rdata, core_rvalid} !== {1'b1, 32'hC0DE0180, 1'b0}) begin
         bad++; $display("FAIL drop_complete: got ldrv=%b ldrd=%h rv=%b want 1 c0de0180 0",
                         ld_rvalid, ld_rdata, core_rvalid);
      end
      drive_pt();
      @(negedge clk);
      total++;
      if (hits_300 !== 0) begin bad++; $display("FAIL drop_no_access: got %0d strobes want 0", hits_300); end
      drive_pt();
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] adrs [3];
      int            gc   [3];
      logic          got;
      adrs[0] = 32'h04; adrs[1] = 32'h08; adrs[2] = 32'h0C;
      for (int k = 0; k < 3; k++) gc[k] = 0;
      core_req = 1'b1; core_we = 1'b0; core_adr = adrs[0];
      for (int k = 0; k < 3; k++) begin
         got = 1'b0;
         for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (core_gnt) begin got = 1'b1; break; end
            drive_pt();
         end
         total++;
         if (got !== 1'b1) begin
            bad++; $display("FAIL b2b_gnt_timeout[%0d]: got no grant want grant", k);
            core_req = 1'b0;
            break;
         end
         gc[k] = cyc;
         drive_pt();
         core_req = 1'b0;
         drive_pt();
         drive_pt();
         if (k < 2) begin core_req = 1'b1; core_adr = adrs[k+1]; end
         @(negedge clk);
         total++;
         if ({core_rvalid, core_rdata} !== {1'b1, exp_rd(adrs[k])}) begin
            bad++; $display("FAIL b2b_rdata[%0d]: got rv=%b rd=%h want 1 %h", k, core_rvalid, core_rdata, exp_rd(adrs[k]));
         end
         drive_pt();
      end
      total++;
      if (gc[1] - gc[0] !== 4) begin bad++; $display("FAIL b2b_gap01: got %0d want 4", gc[1] - gc[0]); end
      total++;
      if (gc[2] - gc[1] !== 4) begin bad++; $display("FAIL b2b_gap12: got %0d want 4", gc[2] - gc[1]); end
      repeat (3) drive_pt();
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; hits_300 = 0;
      test_reset();
      test_core_read();
      test_loader_write();
      test_starvation();
      test_core_drop();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
